// File: rtl/game_pkg.sv
// Shared encodings and widths for the game round controller.
// State codes are fixed because state_dbg exposes them directly.
package game_pkg;
  localparam int LVL_W   = 3;
  localparam int LIVES_W = 3;
  localparam logic [LVL_W-1:0] LEVEL_MIN = 3'd1;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_CONFIG    = 3'd1;
  localparam logic [2:0] S_ARM       = 3'd2;
  localparam logic [2:0] S_RUN       = 3'd3;
  localparam logic [2:0] S_LEVEL_UP  = 3'd4;
  localparam logic [2:0] S_LOSE      = 3'd5;
  localparam logic [2:0] S_GAME_OVER = 3'd6;

  typedef enum logic [2:0] {
    ST_IDLE      = S_IDLE,
    ST_CONFIG    = S_CONFIG,
    ST_ARM       = S_ARM,
    ST_RUN       = S_RUN,
    ST_LEVEL_UP  = S_LEVEL_UP,
    ST_LOSE      = S_LOSE,
    ST_GAME_OVER = S_GAME_OVER
  } state_t;
endpackage

// File: rtl/grc_hold_counter.sv
// Result-hold timer: load sets HOLD-1, dec counts down to zero, done flags zero.
// A state that decrements from entry therefore lasts exactly HOLD cycles.
module grc_hold_counter #(
  parameter int HOLD = 50
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic dec,
  output logic done
);
  localparam int W = $clog2(HOLD + 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= W'(HOLD - 1);
    end else if (dec && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = (cnt == '0);
endmodule

// File: rtl/game_round_controller.sv
// Round sequencer for a multi-level countdown game: drives timer reload/enable, score, lives.
// Optional pause input enabled by defining GRC_PAUSE_EN.
module game_round_controller
  import game_pkg::*;
#(
  parameter int MAX_LEVEL      = 7,
  parameter int START_LIVES    = 3,
  parameter int HITS_PER_LEVEL = 4,
  parameter int SCORE_W        = 8,
  parameter int RESULT_HOLD    = 50
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               hit,
  input  logic               abort,
  input  logic               timeout,
`ifdef GRC_PAUSE_EN
  input  logic               pause,
`endif
  output logic               timerReconfig,
  output logic               timerEnable,
  output logic [LVL_W-1:0]   gameLevel,
  output logic [SCORE_W-1:0] score,
  output logic [LIVES_W-1:0] lives,
  output logic               game_over,
  output logic               game_won,
  output logic [2:0]         state_dbg
);
  localparam int HC_W = $clog2(HITS_PER_LEVEL + 1);

  state_t           state;
  logic [HC_W-1:0]  hit_cnt;
  logic             last_clear;
  logic             hold_done;
  logic             paused;
  logic [SCORE_W:0] score_sum;
  logic [SCORE_W-1:0] score_next;

`ifdef GRC_PAUSE_EN
  assign paused = pause;
`else
  assign paused = 1'b0;
`endif

  assign score_sum  = {1'b0, score} + (SCORE_W + 1)'(gameLevel);
  assign score_next = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
  assign state_dbg  = state;

  // RUN always precedes LEVEL_UP/LOSE, so reloading there arms the hold on entry.
  grc_hold_counter #(.HOLD(RESULT_HOLD)) u_hold (
    .clk  (clk),
    .rst  (rst),
    .load (state == ST_RUN),
    .dec  (state == ST_LEVEL_UP || state == ST_LOSE),
    .done (hold_done)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= ST_IDLE;
      timerReconfig <= 1'b0;
      timerEnable   <= 1'b0;
      gameLevel     <= LEVEL_MIN;
      score         <= '0;
      lives         <= LIVES_W'(START_LIVES);
      game_over     <= 1'b0;
      game_won      <= 1'b0;
      hit_cnt       <= '0;
      last_clear    <= 1'b0;
    end else begin
      timerReconfig <= 1'b0;
      if (abort) begin
        state       <= ST_IDLE;
        timerEnable <= 1'b0;
        game_over   <= 1'b0;
        game_won    <= 1'b0;
        hit_cnt     <= '0;
      end else begin
        case (state)
          ST_IDLE, ST_GAME_OVER: begin
            if (start) begin
              state         <= ST_CONFIG;
              timerReconfig <= 1'b1;
              gameLevel     <= LEVEL_MIN;
              score         <= '0;
              lives         <= LIVES_W'(START_LIVES);
              hit_cnt       <= '0;
              game_over     <= 1'b0;
              game_won      <= 1'b0;
            end
          end
          ST_CONFIG: state <= ST_ARM;
          ST_ARM: begin
            state       <= ST_RUN;
            timerEnable <= 1'b1;
          end
          ST_RUN: begin
            timerEnable <= !paused;
            if (timeout) begin
              state       <= ST_LOSE;
              timerEnable <= 1'b0;
              lives       <= lives - 3'd1;
              hit_cnt     <= '0;
            end else if (hit && !paused) begin
              score <= score_next;
              if (hit_cnt == HC_W'(HITS_PER_LEVEL - 1)) begin
                state       <= ST_LEVEL_UP;
                timerEnable <= 1'b0;
                hit_cnt     <= '0;
                // Level advances on entry; the top level is remembered so LEVEL_UP can end the game.
                last_clear  <= (gameLevel == LVL_W'(MAX_LEVEL));
                if (gameLevel != LVL_W'(MAX_LEVEL)) gameLevel <= gameLevel + 3'd1;
              end else begin
                hit_cnt <= hit_cnt + 1'b1;
              end
            end
          end
          ST_LEVEL_UP: begin
            if (last_clear) begin
              state     <= ST_GAME_OVER;
              game_over <= 1'b1;
              game_won  <= 1'b1;
            end else if (hold_done) begin
              state         <= ST_CONFIG;
              timerReconfig <= 1'b1;
            end
          end
          ST_LOSE: begin
            if (lives == '0) begin
              state     <= ST_GAME_OVER;
              game_over <= 1'b1;
            end else if (hold_done) begin
              state         <= ST_CONFIG;
              timerReconfig <= 1'b1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end
endmodule
